// File: rtl/butterfly_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_unit_pipe
// Description : 4-stage flow-controlled radix-2 DIT butterfly, A' = A + B*W,
//               B' = A - B*W, with per-beat conj(W), /2 scaling and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_unit_pipe #(
    parameter int DATA_W = 32,
    parameter int TW_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] a_in,
    input  logic [2*DATA_W-1:0] b_in,
    input  logic [2*TW_W-1:0]   tw_in,
    input  logic                inverse,
    input  logic                scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] a_out,
    output logic [2*DATA_W-1:0] b_out,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int WW = TW_W + 1;
    localparam int PW = DATA_W + TW_W + 1;
    localparam int RW = DATA_W + 2;
    localparam int XW = DATA_W + 3;

    localparam logic [TW_W-1:0]       c_TW_MAX = {1'b0, {(TW_W-1){1'b1}}};
    localparam logic [WW-1:0]         c_TW_ONE = {2'b01, {(TW_W-1){1'b0}}};
    localparam logic [PW:0]           c_RND    = {{(PW-TW_W+2){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [XW-1:0]  c_ONE_X  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0]  c_MAX_X  = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0]  c_MIN_X  = {4'b1111, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     c_MAX_D  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]     c_MIN_D  = {1'b1, {(DATA_W-1){1'b0}}};

    // Max positive twiddle is treated as exactly 1.0 so unity rotations are lossless.
    function automatic logic [WW-1:0] map_tw(input logic [TW_W-1:0] t);
        return (t == c_TW_MAX) ? c_TW_ONE : {t[TW_W-1], t};
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic [DATA_W-1:0] x,
                                                 input logic [WW-1:0]     w);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] we;
        xe = {{(PW-DATA_W){x[DATA_W-1]}}, x};
        we = {{(PW-WW){w[WW-1]}}, w};
        return xe * we;
    endfunction

    function automatic logic [PW:0] rnd(input logic [PW-1:0] p,
                                        input logic [PW-1:0] q,
                                        input logic          sub);
        logic signed [PW:0] pe;
        logic signed [PW:0] qe;
        pe = {p[PW-1], p};
        qe = {q[PW-1], q};
        return (sub ? (pe - qe) : (pe + qe)) + c_RND;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [DATA_W:0] sat(input logic [DATA_W-1:0] a,
                                            input logic [RW-1:0]     p,
                                            input logic              sub,
                                            input logic              sc);
        logic signed [XW-1:0] ae;
        logic signed [XW-1:0] pe;
        logic signed [XW-1:0] s;
        ae = {{3{a[DATA_W-1]}}, a};
        pe = {p[RW-1], p};
        s  = sub ? (ae - pe) : (ae + pe);
        if (sc) s = (s + c_ONE_X) >>> 1;
        if (s > c_MAX_X)      return {1'b1, c_MAX_D};
        else if (s < c_MIN_X) return {1'b1, c_MIN_D};
        else                  return {1'b0, s[DATA_W-1:0]};
    endfunction

    logic                en;

    logic                v1_q, v1_d, sc1_q, sc1_d;
    logic [2*DATA_W-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [WW-1:0]       wr1_q, wr1_d, wi1_q, wi1_d;

    logic                v2_q, v2_d, sc2_q, sc2_d;
    logic [2*DATA_W-1:0] a2_q, a2_d;
    logic [PW-1:0]       prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;

    logic                v3_q, v3_d, sc3_q, sc3_d;
    logic [2*DATA_W-1:0] a3_q, a3_d;
    logic [RW-1:0]       pr3_q, pr3_d, pi3_q, pi3_d;

    logic                out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [2*DATA_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;

    logic [WW-1:0]       w_wi_map;
    logic [PW:0]         w_pr_full, w_pi_full;
    logic [DATA_W:0]     w_sa_re, w_sa_im, w_sb_re, w_sb_im;
    logic                w_unused_rnd;

    assign en        = !out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;

    always_comb begin
        w_wi_map  = map_tw(tw_in[TW_W-1:0]);
        w_pr_full = rnd(prr_q, pii_q, 1'b1);
        w_pi_full = rnd(pri_q, pir_q, 1'b0);
        w_sa_re   = sat(a3_q[2*DATA_W-1:DATA_W], pr3_q, 1'b0, sc3_q);
        w_sa_im   = sat(a3_q[DATA_W-1:0],        pi3_q, 1'b0, sc3_q);
        w_sb_re   = sat(a3_q[2*DATA_W-1:DATA_W], pr3_q, 1'b1, sc3_q);
        w_sb_im   = sat(a3_q[DATA_W-1:0],        pi3_q, 1'b1, sc3_q);

        v1_d = v1_q;   sc1_d = sc1_q; a1_d = a1_q; b1_d = b1_q;
        wr1_d = wr1_q; wi1_d = wi1_q;
        v2_d = v2_q;   sc2_d = sc2_q; a2_d = a2_q;
        prr_d = prr_q; pii_d = pii_q; pri_d = pri_q; pir_d = pir_q;
        v3_d = v3_q;   sc3_d = sc3_q; a3_d = a3_q;
        pr3_d = pr3_q; pi3_d = pi3_q;
        out_valid_d = out_valid_q;
        a_out_d = a_out_q; b_out_d = b_out_q;

        if (en) begin
            v1_d  = in_valid;
            sc1_d = scale;
            a1_d  = a_in;
            b1_d  = b_in;
            wr1_d = map_tw(tw_in[2*TW_W-1:TW_W]);
            wi1_d = inverse ? (~w_wi_map + 1'b1) : w_wi_map;

            v2_d  = v1_q;
            sc2_d = sc1_q;
            a2_d  = a1_q;
            prr_d = mul(b1_q[2*DATA_W-1:DATA_W], wr1_q);
            pii_d = mul(b1_q[DATA_W-1:0],        wi1_q);
            pri_d = mul(b1_q[2*DATA_W-1:DATA_W], wi1_q);
            pir_d = mul(b1_q[DATA_W-1:0],        wr1_q);

            v3_d  = v2_q;
            sc3_d = sc2_q;
            a3_d  = a2_q;
            pr3_d = w_pr_full[TW_W-1 +: RW];
            pi3_d = w_pi_full[TW_W-1 +: RW];

            out_valid_d = v3_q;
            a_out_d     = {w_sa_re[DATA_W-1:0], w_sa_im[DATA_W-1:0]};
            b_out_d     = {w_sb_re[DATA_W-1:0], w_sb_im[DATA_W-1:0]};
        end

        // Clear first so a same-cycle saturation wins.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (en && v3_q &&
            (w_sa_re[DATA_W] | w_sa_im[DATA_W] | w_sb_re[DATA_W] | w_sb_im[DATA_W]))
            ovf_d = 1'b1;
    end

    // Rounding carry bits below the kept window and the spare top bit.
    assign w_unused_rnd = ^{w_pr_full[PW], w_pr_full[TW_W-2:0],
                            w_pi_full[PW], w_pi_full[TW_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; sc1_q <= 1'b0; a1_q <= '0; b1_q <= '0;
            wr1_q <= '0; wi1_q <= '0;
            v2_q <= 1'b0; sc2_q <= 1'b0; a2_q <= '0;
            prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
            v3_q <= 1'b0; sc3_q <= 1'b0; a3_q <= '0;
            pr3_q <= '0; pi3_q <= '0;
            out_valid_q <= 1'b0; a_out_q <= '0; b_out_q <= '0; ovf_q <= 1'b0;
        end else begin
            v1_q <= v1_d; sc1_q <= sc1_d; a1_q <= a1_d; b1_q <= b1_d;
            wr1_q <= wr1_d; wi1_q <= wi1_d;
            v2_q <= v2_d; sc2_q <= sc2_d; a2_q <= a2_d;
            prr_q <= prr_d; pii_q <= pii_d; pri_q <= pri_d; pir_q <= pir_d;
            v3_q <= v3_d; sc3_q <= sc3_d; a3_q <= a3_d;
            pr3_q <= pr3_d; pi3_q <= pi3_d;
            out_valid_q <= out_valid_d; a_out_q <= a_out_d; b_out_q <= b_out_d;
            ovf_q <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_butterfly_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_butterfly_unit_pipe
// Description : Directed bench for butterfly_unit_pipe with a streamed
//               backpressure section checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_unit_pipe;

    localparam longint c_LMAX = 64'sd2147483647;
    localparam longint c_LMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] a_in = '0, b_in = '0;
    logic [31:0] tw_in = '0;
    logic        inverse = 1'b0, scale = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [63:0] a_out, b_out;
    logic        ovf, ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        cap_en = 1'b0;
    logic [63:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    butterfly_unit_pipe #(.DATA_W(32), .TW_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .tw_in(tw_in), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always @(negedge clk)
        if (cap_en && out_valid && out_ready) begin
            got_a.push_back(a_out);
            got_b.push_back(b_out);
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cx(input int re, input int im);
        return {re, im};
    endfunction

    function automatic logic [31:0] clip(input longint s, input logic sc);
        longint t;
        t = s;
        if (sc) t = (t + 1) >>> 1;
        if (t > c_LMAX) t = c_LMAX;
        else if (t < c_LMIN) t = c_LMIN;
        return t[31:0];
    endfunction

    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [31:0] tw,
                         input logic inv, input logic sc,
                         output logic [63:0] ao, output logic [63:0] bo);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        ar = longint'($signed(a[63:32]));
        ai = longint'($signed(a[31:0]));
        br = longint'($signed(b[63:32]));
        bi = longint'($signed(b[31:0]));
        wr = (tw[31:16] == 16'h7fff) ? 64'sd32768 : longint'($signed(tw[31:16]));
        wi = (tw[15:0]  == 16'h7fff) ? 64'sd32768 : longint'($signed(tw[15:0]));
        if (inv) wi = -wi;
        pr = (br * wr - bi * wi + 16384) >>> 15;
        pi = (br * wi + bi * wr + 16384) >>> 15;
        ao = {clip(ar + pr, sc), clip(ai + pi, sc)};
        bo = {clip(ar - pr, sc), clip(ai - pi, sc)};
    endtask

    // One isolated beat: checks 4-cycle latency and both outputs.
    task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [31:0] tw, input logic inv, input logic sc,
                          input logic [63:0] ea, input logic [63:0] eb);
        int lat;
        @(posedge clk); #1;
        a_in = a; b_in = b; tw_in = tw; inverse = inv; scale = sc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, ".lat"}, 64'(lat), 64'd4);
        chk({tag, ".a"}, a_out, ea);
        chk({tag, ".b"}, b_out, eb);
    endtask

    initial begin
        logic [63:0] va[16], vb[16];
        logic [31:0] vt[16];
        logic        vi[16], vs[16];
        logic [63:0] ma, mb;
        int sent, cyc, bad;

        #1 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.a_out", a_out, 64'd0);
        chk("rst.b_out", b_out, 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        #30 rst_n = 1'b1;
        #1 chk("rst.in_ready", 64'(in_ready), 64'd1);

        single("t1", cx(100, 0), cx(50, 0), 32'h7fff_0000, 1'b0, 1'b0, cx(150, 0), cx(50, 0));
        chk("t1.ovf", 64'(ovf), 64'd0);
        single("t2", cx(0, 0), cx(1000, 0), 32'h0000_8000, 1'b0, 1'b0, cx(0, -1000), cx(0, 1000));
        single("t2inv", cx(0, 0), cx(1000, 0), 32'h0000_8000, 1'b1, 1'b0, cx(0, 1000), cx(0, -1000));
        single("t3", cx(3, -3), cx(0, 0), 32'h7fff_0000, 1'b0, 1'b1, cx(2, -1), cx(2, -1));
        chk("t3.ovf", 64'(ovf), 64'd0);

        single("t4sat", cx(32'h7fffffff, 0), cx(1, 0), 32'h7fff_0000, 1'b0, 1'b0,
               cx(32'h7fffffff, 0), cx(32'h7ffffffe, 0));
        chk("t4.ovf_set", 64'(ovf), 64'd1);
        repeat (3) @(posedge clk);
        #1 chk("t4.ovf_hold", 64'(ovf), 64'd1);
        single("t4scl", cx(32'h7fffffff, 0), cx(1, 0), 32'h7fff_0000, 1'b0, 1'b1,
               cx(32'h40000000, 0), cx(32'h3fffffff, 0));
        chk("t4.ovf_still", 64'(ovf), 64'd1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("t4.ovf_clr", 64'(ovf), 64'd0);

        for (int i = 0; i < 16; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
            vt[i] = $urandom;
            vi[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        vt[3] = 32'h7fff_7fff;
        vt[4] = 32'h8000_8000;
        cap_en = 1'b1;
        sent = 0;
        cyc = 0;
        while ((sent < 16 || got_a.size() < 16) && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 8 && cyc < 11);
            if (sent < 16) begin
                a_in = va[sent]; b_in = vb[sent]; tw_in = vt[sent];
                inverse = vi[sent]; scale = vs[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 8 && cyc < 11) chk("t5.stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) begin
                model(va[sent], vb[sent], vt[sent], vi[sent], vs[sent], ma, mb);
                exp_a.push_back(ma);
                exp_b.push_back(mb);
                sent++;
            end
            cyc++;
        end
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 cap_en = 1'b0;
        chk("t5.count", 64'(got_a.size()), 64'd16);
        for (int i = 0; i < 16 && i < got_a.size() && i < exp_a.size(); i++) begin
            chk($sformatf("t5.a[%0d]", i), got_a[i], exp_a[i]);
            chk($sformatf("t5.b[%0d]", i), got_b[i], exp_b[i]);
        end

        single("t6pre", cx(32'h7fffffff, 0), cx(1, 0), 32'h7fff_0000, 1'b0, 1'b0,
               cx(32'h7fffffff, 0), cx(32'h7ffffffe, 0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a_in = cx(100, 0); b_in = cx(50, 0); tw_in = 32'h7fff_0000;
            inverse = 1'b0; scale = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("t6.pre_valid", 64'(out_valid), 64'd1);
        chk("t6.pre_ovf", 64'(ovf), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.out_valid", 64'(out_valid), 64'd0);
        chk("t6.a_out", a_out, 64'd0);
        chk("t6.b_out", b_out, 64'd0);
        chk("t6.ovf", 64'(ovf), 64'd0);
        #20 rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("t6.no_stale", 64'(bad), 64'd0);
        single("t6post", cx(100, 0), cx(50, 0), 32'h7fff_0000, 1'b0, 1'b0, cx(150, 0), cx(50, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
